// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// The granted request is registered into a single issue stage that drives the
// ALU; the result is captured into a one-entry response buffer per requester.
module alu_issue_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter bit          RR_INIT = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_op,
  input  logic [1:0]          req_op_imm,
  input  logic [5:0]          req_funct3,
  input  logic [13:0]         req_funct7,
  input  logic [2*XLEN-1:0]   req_a,
  input  logic [2*XLEN-1:0]   req_b,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [2*XLEN-1:0]   rsp_t,
  output logic                alu_op,
  output logic                alu_op_imm,
  output logic [2:0]          alu_funct3,
  output logic [6:0]          alu_funct7,
  output logic [XLEN-1:0]     alu_a,
  output logic [XLEN-1:0]     alu_b,
  input  logic [XLEN-1:0]     alu_t
);

  localparam int unsigned F3W = 3;
  localparam int unsigned F7W = 7;

  logic [1:0] rsp_hs;
  logic [1:0] elig;
  logic [1:0] grant;
  logic       acc;
  logic       acc_tag;

  logic                      last_grant_q, last_grant_d;
  logic [1:0]                inflight_q, inflight_d;
  logic                      iss_valid_q, iss_valid_d;
  logic                      iss_tag_q, iss_tag_d;
  logic                      iss_op_q, iss_op_d;
  logic                      iss_op_imm_q, iss_op_imm_d;
  logic [F3W-1:0]            iss_funct3_q, iss_funct3_d;
  logic [F7W-1:0]            iss_funct7_q, iss_funct7_d;
  logic [XLEN-1:0]           iss_a_q, iss_a_d;
  logic [XLEN-1:0]           iss_b_q, iss_b_d;
  logic [1:0]                rsp_valid_q, rsp_valid_d;
  logic [1:0][XLEN-1:0]      rsp_t_q, rsp_t_d;

  // Eligibility and round-robin grant; a requester whose response is being
  // consumed this cycle may issue again on the same edge.
  always_comb begin
    rsp_hs = rsp_valid_q & rsp_ready;
    elig   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_valid[i] & ~flush & rst_n & (~inflight_q[i] | rsp_hs[i]);
    end
    grant = elig;
    if (elig == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end
    acc     = |grant;
    acc_tag = grant[1];
  end

  // Next-state: issue stage load/empty, response capture, inflight tracking.
  always_comb begin
    last_grant_d = last_grant_q;
    inflight_d   = inflight_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_t_d      = rsp_t_q;
    iss_valid_d  = 1'b0;
    iss_tag_d    = 1'b0;
    iss_op_d     = 1'b0;
    iss_op_imm_d = 1'b0;
    iss_funct3_d = '0;
    iss_funct7_d = '0;
    iss_a_d      = '0;
    iss_b_d      = '0;

    if (acc) begin
      iss_valid_d  = 1'b1;
      iss_tag_d    = acc_tag;
      iss_op_d     = acc_tag ? req_op[1]     : req_op[0];
      iss_op_imm_d = acc_tag ? req_op_imm[1] : req_op_imm[0];
      iss_funct3_d = acc_tag ? req_funct3[5:3]  : req_funct3[2:0];
      iss_funct7_d = acc_tag ? req_funct7[13:7] : req_funct7[6:0];
      iss_a_d      = acc_tag ? req_a[2*XLEN-1:XLEN] : req_a[XLEN-1:0];
      iss_b_d      = acc_tag ? req_b[2*XLEN-1:XLEN] : req_b[XLEN-1:0];
      last_grant_d = acc_tag;
    end

    for (int i = 0; i < 2; i++) begin
      if (iss_valid_q && (iss_tag_q == 1'(i))) begin
        rsp_valid_d[i] = 1'b1;
        rsp_t_d[i]     = alu_t;
      end else if (rsp_hs[i]) begin
        rsp_valid_d[i] = 1'b0;
      end

      if (acc && (acc_tag == 1'(i))) begin
        inflight_d[i] = 1'b1;
      end else if (rsp_hs[i]) begin
        inflight_d[i] = 1'b0;
      end
    end

    if (flush) begin
      inflight_d  = 2'b00;
      rsp_valid_d = 2'b00;
      rsp_t_d     = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= RR_INIT;
      inflight_q   <= 2'b00;
      iss_valid_q  <= 1'b0;
      iss_tag_q    <= 1'b0;
      iss_op_q     <= 1'b0;
      iss_op_imm_q <= 1'b0;
      iss_funct3_q <= '0;
      iss_funct7_q <= '0;
      iss_a_q      <= '0;
      iss_b_q      <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_t_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      inflight_q   <= inflight_d;
      iss_valid_q  <= iss_valid_d;
      iss_tag_q    <= iss_tag_d;
      iss_op_q     <= iss_op_d;
      iss_op_imm_q <= iss_op_imm_d;
      iss_funct3_q <= iss_funct3_d;
      iss_funct7_q <= iss_funct7_d;
      iss_a_q      <= iss_a_d;
      iss_b_q      <= iss_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_t_q      <= rsp_t_d;
    end
  end

  assign req_ready  = grant;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_t      = rsp_t_q;
  assign alu_op     = iss_op_q;
  assign alu_op_imm = iss_op_imm_q;
  assign alu_funct3 = iss_funct3_q;
  assign alu_funct7 = iss_funct7_q;
  assign alu_a      = iss_a_q;
  assign alu_b      = iss_b_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: behavioural ALU on the alu_* port, plus a
// transaction-level model of grants, outstanding ops and response timing.
module tb_alu_issue_arbiter;

  localparam int unsigned XLEN = 32;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_op;
  logic [1:0]        req_op_imm;
  logic [5:0]        req_funct3;
  logic [13:0]       req_funct7;
  logic [2*XLEN-1:0] req_a;
  logic [2*XLEN-1:0] req_b;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [2*XLEN-1:0] rsp_t;
  logic              alu_op;
  logic              alu_op_imm;
  logic [2:0]        alu_funct3;
  logic [6:0]        alu_funct7;
  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  logic [XLEN-1:0]   alu_t;

  alu_issue_arbiter #(.XLEN(XLEN), .RR_INIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_op_imm(req_op_imm),
    .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_t(rsp_t),
    .alu_op(alu_op), .alu_op_imm(alu_op_imm),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_a(alu_a), .alu_b(alu_b), .alu_t(alu_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RV32I-style integer ALU; the invalid class returns a recognisable pattern.
  function automatic logic [31:0] alu_f(input logic op, input logic opi,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    if (!op && !opi) return a ^ 32'hBAD0_0000;
    case (f3)
      3'd0: return (op && f7[5]) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return f7[5] ? 32'($signed(a) >>> sh) : (a >> sh);
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  always_comb alu_t = alu_f(alu_op, alu_op_imm, alu_funct3, alu_funct7, alu_a, alu_b);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Model: an op accepted on edge n is outstanding until its response is
  // consumed; the response is visible from edge n+1 onward.
  int          edges = 0;
  bit          busy[2];
  int          acc_edge[2];
  logic [31:0] mval[2];
  logic [31:0] ma[2];
  logic [31:0] mb[2];
  bit          last = 1'b1;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) busy[i] = 1'b0;
    last = 1'b1;
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic step(input logic [1:0] v, input logic [1:0] op, input logic [1:0] opi,
                      input logic [5:0] f3, input logic [13:0] f7,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic [1:0] rr, input logic fl);
    logic [1:0]  exv, elig, gr;
    logic [31:0] ea, eb;
    @(negedge clk);
    req_valid = v; req_op = op; req_op_imm = opi; req_funct3 = f3; req_funct7 = f7;
    req_a = a; req_b = b; rsp_ready = rr; flush = fl;
    #1;
    ea = '0; eb = '0;
    for (int i = 0; i < 2; i++) begin
      exv[i] = busy[i] && (edges >= acc_edge[i] + 1);
      if (busy[i] && edges == acc_edge[i]) begin ea = ma[i]; eb = mb[i]; end
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(exv));
    for (int i = 0; i < 2; i++)
      if (exv[i]) chk($sformatf("rsp_t%0d", i), 64'(rsp_t[i*32 +: 32]), 64'(mval[i]));
    chk("alu_a", 64'(alu_a), 64'(ea));
    chk("alu_b", 64'(alu_b), 64'(eb));
    for (int i = 0; i < 2; i++)
      elig[i] = v[i] && !fl && (!busy[i] || (exv[i] && rr[i]));
    gr = elig;
    if (elig == 2'b11) begin
      gr = 2'b00;
      gr[!last] = 1'b1;
    end
    chk("req_ready", 64'(req_ready), 64'(gr));
    if (fl) begin
      busy[0] = 1'b0; busy[1] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (exv[i] && rr[i]) busy[i] = 1'b0;
        if (gr[i]) begin
          busy[i]     = 1'b1;
          acc_edge[i] = edges + 1;
          ma[i]       = a[i*32 +: 32];
          mb[i]       = b[i*32 +: 32];
          mval[i]     = alu_f(op[i], opi[i], f3[i*3 +: 3], f7[i*7 +: 7], ma[i], mb[i]);
          last        = (i == 1);
        end
      end
    end
    @(posedge clk);
    edges++;
  endtask

  task automatic one(input int i, input logic op, input logic opi, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] rr, input logic fl);
    logic [1:0] v, o, oi;
    logic [5:0] f3v;
    logic [13:0] f7v;
    logic [63:0] av, bv;
    v = '0; o = '0; oi = '0; f3v = '0; f7v = '0; av = '0; bv = '0;
    v[i] = 1'b1; o[i] = op; oi[i] = opi;
    f3v[i*3 +: 3] = f3; f7v[i*7 +: 7] = f7;
    av[i*32 +: 32] = a; bv[i*32 +: 32] = b;
    step(v, o, oi, f3v, f7v, av, bv, rr, fl);
  endtask

  task automatic idle(input logic [1:0] rr, input logic fl);
    step(2'b00, 2'b00, 2'b00, '0, '0, '0, '0, rr, fl);
  endtask

  // Checks a freshly landed response just after the edge that produced it.
  task automatic expect_rsp(input int i, input logic [31:0] val);
    #1;
    chk($sformatf("rsp_valid%0d_direct", i), 64'(rsp_valid[i]), 64'(1));
    chk($sformatf("rsp_t%0d_direct", i), 64'(rsp_t[i*32 +: 32]), 64'(val));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = '0; req_op = '0; req_op_imm = '0;
    req_funct3 = '0; req_funct7 = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    model_reset();
    #12;
    chk("reset_req_ready", 64'(req_ready), 64'(0));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_rsp_t", rsp_t, 64'(0));
    chk("reset_alu_ctl", 64'({alu_op, alu_op_imm, alu_funct3, alu_funct7}), 64'(0));
    chk("reset_alu_ab", {alu_a, alu_b}, 64'(0));
    @(negedge clk); rst_n = 1'b1;

    // Tie after reset: SUB on req0 wins, SLT on req1 follows.
    step(2'b11, 2'b11, 2'b00, {3'd2, 3'd0}, {7'd0, 7'h20},
         {32'(-100), 32'd20}, {32'd4, 32'd7}, 2'b11, 1'b0);
    step(2'b10, 2'b11, 2'b00, {3'd2, 3'd0}, {7'd0, 7'h20},
         {32'(-100), 32'd20}, {32'd4, 32'd7}, 2'b11, 1'b0);
    expect_rsp(0, 32'd13);
    idle(2'b11, 1'b0);
    expect_rsp(1, 32'd1);
    idle(2'b11, 1'b0);

    // Single ADD, then a tie with req0 granted last goes to req1.
    one(0, 1'b1, 1'b0, 3'd0, 7'd0, 32'd20, 32'd7, 2'b11, 1'b0);
    idle(2'b11, 1'b0);
    expect_rsp(0, 32'd27);
    idle(2'b11, 1'b0);
    step(2'b11, 2'b11, 2'b00, '0, '0, {32'd3, 32'd1}, {32'd4, 32'd2}, 2'b11, 1'b0);
    step(2'b01, 2'b11, 2'b00, '0, '0, {32'd3, 32'd1}, {32'd4, 32'd2}, 2'b11, 1'b0);
    repeat (3) idle(2'b11, 1'b0);

    // Immediate class: ORI and SRAI.
    one(1, 1'b0, 1'b1, 3'd6, 7'd0, 32'h2000_1000, 32'h0000_0504, 2'b11, 1'b0);
    idle(2'b11, 1'b0);
    expect_rsp(1, 32'h2000_1504);
    idle(2'b11, 1'b0);
    one(1, 1'b0, 1'b1, 3'd5, 7'h20, 32'(-100), 32'd4, 2'b11, 1'b0);
    idle(2'b11, 1'b0);
    expect_rsp(1, 32'hFFFF_FFF9);
    idle(2'b11, 1'b0);

    // Backpressure on req0 while req1 keeps flowing; invalid class on req1.
    one(0, 1'b1, 1'b0, 3'd4, 7'd0, 32'h0F0F_0F0F, 32'h00FF_00FF, 2'b10, 1'b0);
    idle(2'b10, 1'b0);
    for (int k = 0; k < 5; k++)
      step(2'b11, 2'b01, 2'b00, {3'd0, 3'd0}, '0,
           {32'(k * 11), 32'd9}, {32'(k), 32'd9}, 2'b10, 1'b0);
    step(2'b01, 2'b01, 2'b00, {3'd0, 3'd7}, '0,
         {32'd0, 32'hF0F0_1234}, {32'd0, 32'h0000_FFFF}, 2'b11, 1'b0);
    repeat (3) idle(2'b11, 1'b0);

    // Flush right after an accept: no response, req0 re-accepted afterwards.
    one(0, 1'b1, 1'b0, 3'd1, 7'd0, 32'd3, 32'd4, 2'b11, 1'b0);
    one(0, 1'b1, 1'b0, 3'd1, 7'd0, 32'd5, 32'd2, 2'b11, 1'b1);
    one(0, 1'b1, 1'b0, 3'd1, 7'd0, 32'd5, 32'd2, 2'b11, 1'b0);
    repeat (3) idle(2'b11, 1'b0);

    // Async reset between accept and result.
    one(0, 1'b1, 1'b0, 3'd0, 7'd0, 32'd20, 32'd7, 2'b11, 1'b0);
    #2 rst_n = 1'b0;
    req_valid = 2'b00;
    #1;
    chk("async_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("async_alu_a", 64'(alu_a), 64'(0));
    chk("async_alu_ctl", 64'({alu_op, alu_op_imm, alu_funct3, alu_funct7}), 64'(0));
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step(2'b11, 2'b11, 2'b00, '0, '0, {32'd7, 32'd8}, {32'd1, 32'd2}, 2'b11, 1'b0);
    repeat (3) idle(2'b11, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [1:0]  rv, rop, ropi, rr;
      logic [5:0]  rf3;
      logic [13:0] rf7;
      logic [63:0] ra, rb;
      logic        rfl;
      rv   = 2'($urandom);
      rop  = 2'($urandom);
      ropi = 2'($urandom);
      rf3  = 6'($urandom);
      rf7  = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
              ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00};
      ra   = {32'($urandom), ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom)};
      rb   = {32'($urandom), 32'($urandom)};
      rr   = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      rfl  = ($urandom_range(0, 31) == 0);
      step(rv, rop, ropi, rf3, rf7, ra, rb, rr, rfl);
    end
    repeat (4) idle(2'b11, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
